quad_encoder_tx: RTL and testbench
==================================

Name: quad_encoder_tx

Overview:
- Quadrature transmitter that emulates a rotary encoder, producing the quadA/quadB pair consumed by the pong paddle decoder.
- Motion comes from two board push-buttons (auto-repeat while held) or from a valid/ready step interface driven by a demo/attract-mode controller.
- Outputs feed the paddle quadrature inputs directly, or board pins looped back, so the board runs without a physical encoder.

Parameters:
- STEP_DIV, 8: minimum clk cycles between successive quadrature edges (legal range 4..65535). Guarantees the decoder's 3-stage sampler sees every edge.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles required before a button level is accepted (legal range 1..65535).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- btn_up  input  1  raw asynchronous button; held = move in the increment direction.
- btn_down  input  1  raw asynchronous button; held = move in the decrement direction.
- step_valid  input  1  request for one quadrature step.
- step_dir  input  1  0 = increment step, 1 = decrement step; qualified by step_valid.
- step_ready  output  1  block can accept a step this cycle.
- quadA  output  1  quadrature phase A, registered.
- quadB  output  1  quadrature phase B, registered.
- pos_count  output  16  net emitted steps, wraps modulo 2^16.

Behaviour:
- Reset (rst high at posedge):
  - quadA = 0, quadB = 0, pos_count = 0.
  - Gap counter = 0, so step_ready = 1 on the first cycle after reset.
  - Synchronizers and debounced levels = 0; debounce counters = 0.
  - Reset mid-gap aborts the gap. Forcing AB to 00 may itself appear as one edge at the decoder; this is accepted.
- Phase encoding (AB, 2-bit state):
  - Increment sequence: 00 -> 01 -> 11 -> 10 -> 00 (B leads A). The decoder rule "prev A xor new B = 1" gives +1.
  - Decrement sequence: 00 -> 10 -> 11 -> 01 -> 00.
  - Exactly one of A/B toggles per step. A and B never toggle in the same cycle.
- Button path:
  - Each button passes through a 2-FF synchronizer, then a debounce counter.
  - The counter resets whenever the synchronized level differs from the debounced level.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1 with the level still different.
  - Latency from a clean button edge to the debounced change is 2 + DEBOUNCE_CYCLES cycles.
- Gap timer (16-bit):
  - Each emitted edge loads the timer with STEP_DIV-1.
  - The timer decrements to 0 and holds there.
  - step_ready = (timer == 0), combinational from the timer register.
- Step arbitration (evaluated only when timer == 0), in priority order:
  1. step_valid high: the handshake completes in this cycle and a step in step_dir is taken.
  2. Otherwise, exactly one debounced button high: a step in that direction is taken.
  3. Both buttons high, or neither: no step.
- Step timing:
  - A step updates AB and pos_count (+1 or -1, wrapping) at the posedge ending the accept cycle. Visible latency is 1 cycle.
  - step_ready falls the next cycle and stays low for STEP_DIV-1 cycles.
  - A held button therefore repeats every STEP_DIV cycles.
  - step_valid while step_ready = 0 is ignored (not queued). The requester holds valid until the handshake.
  - step_dir is sampled only at the handshake.
- Wrap: pos_count 0xFFFF + 1 -> 0x0000; 0x0000 - 1 -> 0xFFFF. Phase wraps 10 -> 00 forward, 01 -> 00 reverse.

Test Plan:
1. Reset: rst high 2 cycles, then low -> quadA = 0, quadB = 0, pos_count = 0, step_ready = 1 on the first cycle after rst drops.
2. Forward steps (STEP_DIV = 8): step_valid held, step_dir = 0, starting at cycle T -> AB = 01, 11, 10, 00 appearing at T+1, T+9, T+17, T+25; step_ready low 7 cycles after each accept; pos_count = 4.
3. Reverse step from reset: one handshake with step_dir = 1 -> AB = 10, pos_count = 0xFFFF; a second reverse step -> AB = 11, pos_count = 0xFFFE.
4. Debounce (DEBOUNCE_CYCLES = 16): 10-cycle btn_up pulse -> no AB change. btn_up held 100 cycles -> first edge (AB 00 -> 01) at cycle 2+16+1 after the press, then one edge every 8 cycles while held.
5. Arbitration: both buttons held -> AB constant, pos_count unchanged. btn_down held plus step_valid with step_dir = 0 at a ready cycle -> step is increment (AB 00 -> 01, pos_count = 1).
6. Reset mid-operation: rst asserted 3 cycles after an edge (timer = 4) with AB = 11 -> next cycle AB = 00, pos_count = 0, step_ready = 1.

Source files
------------

// File: rtl/quad_encoder_tx.sv
// Quadrature transmitter emulating a rotary encoder: button or valid/ready step
// requests become a paced quadA/quadB Gray-code sequence plus a net step count.
module quad_encoder_tx #(
  parameter int unsigned STEP_DIV        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        step_valid,
  input  logic        step_dir,
  output logic        step_ready,
  output logic        quadA,
  output logic        quadB,
  output logic [15:0] pos_count
);

  localparam logic [15:0] GapLoad = 16'(STEP_DIV - 1);
  localparam logic [15:0] DebLast = 16'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]  btnRaw;
  logic [1:0]  syncFirst;
  logic [1:0]  syncSecond;
  logic [1:0]  debLevel;
  logic [15:0] debCnt [2];
  logic [15:0] gapTimer;
  logic        stepTake;
  logic        stepDown;
  logic [1:0]  nextAb;

  assign btnRaw     = {btn_down, btn_up};
  assign step_ready = (gapTimer == 16'd0);

  // Two-flop synchronizer for the raw button inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncFirst  <= 2'b00;
      syncSecond <= 2'b00;
    end else begin
      syncFirst  <= btnRaw;
      syncSecond <= syncFirst;
    end
  end

  // Debounce: the accepted level flips only after a full run of stable disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      debLevel <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        debCnt[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syncSecond[i] == debLevel[i]) begin
          debCnt[i] <= 16'd0;
        end else if (debCnt[i] == DebLast) begin
          debLevel[i] <= ~debLevel[i];
          debCnt[i]   <= 16'd0;
        end else begin
          debCnt[i] <= debCnt[i] + 16'd1;
        end
      end
    end
  end

  // Arbitration: a handshake beats the buttons; conflicting buttons cancel out.
  always_comb begin
    stepTake = 1'b0;
    stepDown = 1'b0;
    if (gapTimer == 16'd0) begin
      if (step_valid) begin
        stepTake = 1'b1;
        stepDown = step_dir;
      end else if (debLevel == 2'b01) begin
        stepTake = 1'b1;
        stepDown = 1'b0;
      end else if (debLevel == 2'b10) begin
        stepTake = 1'b1;
        stepDown = 1'b1;
      end else begin
        stepTake = 1'b0;
        stepDown = 1'b0;
      end
    end else begin
      stepTake = 1'b0;
      stepDown = 1'b0;
    end
  end

  // Next {A,B}: increment walks 00-01-11-10, decrement walks it backwards.
  always_comb begin
    nextAb = 2'b00;
    case ({quadA, quadB})
      2'b00:   nextAb = stepDown ? 2'b10 : 2'b01;
      2'b01:   nextAb = stepDown ? 2'b00 : 2'b11;
      2'b11:   nextAb = stepDown ? 2'b01 : 2'b10;
      2'b10:   nextAb = stepDown ? 2'b11 : 2'b00;
      default: nextAb = 2'b00;
    endcase
  end

  // Phase outputs, step count and inter-edge gap timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      quadA     <= 1'b0;
      quadB     <= 1'b0;
      pos_count <= 16'd0;
      gapTimer  <= 16'd0;
    end else if (stepTake) begin
      quadA     <= nextAb[1];
      quadB     <= nextAb[0];
      pos_count <= stepDown ? (pos_count - 16'd1) : (pos_count + 16'd1);
      gapTimer  <= GapLoad;
    end else if (gapTimer != 16'd0) begin
      gapTimer <= gapTimer - 16'd1;
    end else begin
      gapTimer <= 16'd0;
    end
  end

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Directed self-checking bench for quad_encoder_tx (STEP_DIV=8, DEBOUNCE_CYCLES=16).
module tb_quad_encoder_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        step_valid = 1'b0;
  logic        step_dir = 1'b0;
  logic        step_ready;
  logic        quadA;
  logic        quadB;
  logic [15:0] pos_count;

  int errors = 0;
  int checks = 0;

  quad_encoder_tx #(.STEP_DIV(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .step_valid(step_valid), .step_dir(step_dir), .step_ready(step_ready),
    .quadA(quadA), .quadB(quadB), .pos_count(pos_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    btn_up = 1'b0; btn_down = 1'b0; step_valid = 1'b0; step_dir = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] ab_of(input int steps);
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    return seq[steps % 4];
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++; if ({quadA, quadB} !== 2'b00) begin errors++; $display("FAIL reset_ab got=%b want=00", {quadA, quadB}); end
    checks++; if (pos_count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h want=0000", pos_count); end
    checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", step_ready); end
  endtask

  task automatic test_forward();
    logic [1:0] expAb [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    step_valid = 1'b1; step_dir = 1'b0;
    for (int s = 0; s < 4; s++) begin
      checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready_hi step%0d got=%b want=1", s, step_ready); end
      tick();
      if (s == 3) step_valid = 1'b0;
      checks++; if ({quadA, quadB} !== expAb[s]) begin errors++; $display("FAIL fwd_ab step%0d got=%b want=%b", s, {quadA, quadB}, expAb[s]); end
      for (int j = 0; j < 7; j++) begin
        checks++; if (step_ready !== 1'b0) begin errors++; $display("FAIL fwd_ready_lo step%0d cyc%0d got=%b want=0", s, j, step_ready); end
        tick();
      end
    end
    checks++; if (pos_count !== 16'd4) begin errors++; $display("FAIL fwd_count got=%h want=0004", pos_count); end
    checks++; if ({quadA, quadB} !== 2'b00) begin errors++; $display("FAIL fwd_final_ab got=%b want=00", {quadA, quadB}); end
  endtask

  task automatic test_reverse_wrap();
    apply_reset();
    step_valid = 1'b1; step_dir = 1'b1;
    tick();
    step_valid = 1'b0;
    checks++; if ({quadA, quadB} !== 2'b10) begin errors++; $display("FAIL rev1_ab got=%b want=10", {quadA, quadB}); end
    checks++; if (pos_count !== 16'hFFFF) begin errors++; $display("FAIL rev1_count got=%h want=ffff", pos_count); end
    for (int j = 0; j < 7; j++) tick();
    step_valid = 1'b1; step_dir = 1'b1;
    tick();
    // Still asserted while not ready, with the opposite direction: must be ignored.
    step_dir = 1'b0;
    tick();
    step_valid = 1'b0;
    checks++; if ({quadA, quadB} !== 2'b11) begin errors++; $display("FAIL rev2_ab got=%b want=11", {quadA, quadB}); end
    checks++; if (pos_count !== 16'hFFFE) begin errors++; $display("FAIL rev2_count got=%h want=fffe", pos_count); end
    for (int j = 0; j < 6; j++) tick();
    step_valid = 1'b1; step_dir = 1'b0;
    tick();
    step_valid = 1'b0;
    checks++; if (pos_count !== 16'hFFFF || {quadA, quadB} !== 2'b10) begin errors++; $display("FAIL wrap_fwd1 got=%h/%b want=ffff/10", pos_count, {quadA, quadB}); end
    for (int j = 0; j < 7; j++) tick();
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    checks++; if (pos_count !== 16'h0000 || {quadA, quadB} !== 2'b00) begin errors++; $display("FAIL wrap_fwd2 got=%h/%b want=0000/00", pos_count, {quadA, quadB}); end
  endtask

  task automatic test_debounce();
    int steps;
    apply_reset();
    btn_up = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_up = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checks++; if ({quadA, quadB} !== 2'b00 || pos_count !== 16'd0) begin errors++; $display("FAIL deb_pulse got=%b/%h want=00/0000", {quadA, quadB}, pos_count); end
    btn_up = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      tick();
      steps = (i >= 19) ? ((i - 19) / 8 + 1) : 0;
      if (steps > 13) steps = 13;
      checks++;
      if ({quadA, quadB} !== ab_of(steps) || pos_count !== 16'(steps)) begin
        errors++;
        $display("FAIL deb_hold cyc%0d got=%b/%h want=%b/%h", i, {quadA, quadB}, pos_count, ab_of(steps), 16'(steps));
      end
      if (i == 100) btn_up = 1'b0;
    end
  endtask

  task automatic test_arbitration();
    apply_reset();
    btn_up = 1'b1; btn_down = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    checks++; if ({quadA, quadB} !== 2'b00 || pos_count !== 16'd0) begin errors++; $display("FAIL arb_both got=%b/%h want=00/0000", {quadA, quadB}, pos_count); end
    btn_up = 1'b0; btn_down = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    btn_down = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    step_valid = 1'b1; step_dir = 1'b0;
    tick();
    step_valid = 1'b0; btn_down = 1'b0;
    checks++; if ({quadA, quadB} !== 2'b01) begin errors++; $display("FAIL arb_valid_ab got=%b want=01", {quadA, quadB}); end
    checks++; if (pos_count !== 16'd1) begin errors++; $display("FAIL arb_valid_count got=%h want=0001", pos_count); end
  endtask

  task automatic test_reset_mid_gap();
    apply_reset();
    step_valid = 1'b1; step_dir = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    step_valid = 1'b0;
    checks++; if ({quadA, quadB} !== 2'b11 || pos_count !== 16'd2) begin errors++; $display("FAIL mid_pre got=%b/%h want=11/0002", {quadA, quadB}, pos_count); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (step_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_lo got=%b want=0", step_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({quadA, quadB} !== 2'b00) begin errors++; $display("FAIL mid_ab got=%b want=00", {quadA, quadB}); end
    checks++; if (pos_count !== 16'd0) begin errors++; $display("FAIL mid_count got=%h want=0000", pos_count); end
    checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b want=1", step_ready); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_debounce();
    test_arbitration();
    test_reset_mid_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
